// File: rtl/instruction_prefetch_queue.sv
// rtl/instruction_prefetch_queue.sv - pipelined AXI-Lite instruction prefetch queue with redirect flush
// Every issued read owns a reserved FIFO slot; a redirect drops responses to reads issued before it.
module instruction_prefetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_N,
  input  logic                       i_Enable,
  input  logic                       i_Redirect,
  input  logic [XLEN-1:0]            i_Redirect_PC,
  output logic [XLEN-1:0]            o_Instruction,
  output logic [XLEN-1:0]            o_Instruction_PC,
  output logic                       o_Instruction_Error,
  output logic                       o_Instruction_Valid,
  input  logic                       i_Instruction_Ready,
  output logic [$clog2(DEPTH+1)-1:0] o_Count,
  output logic [XLEN-1:0]            s_axil_araddr,
  output logic                       s_axil_arvalid,
  input  logic                       s_axil_arready,
  input  logic [XLEN-1:0]            s_axil_rdata,
  input  logic [1:0]                 s_axil_rresp,
  input  logic                       s_axil_rvalid,
  output logic                       s_axil_rready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 2);
  localparam int SW = CW + OW;

  logic            r_arvalid;
  logic [XLEN-1:0] r_araddr;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic            r_rready;
  logic            r_stale;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [DEPTH-1:0] r_err_mem;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_ar_hs;
  logic            w_r_hs;
  logic            w_r_dec;
  logic            w_discard;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_fetch_pc_next;
  logic [OW-1:0]   w_out_after;
  logic [SW-1:0]   w_inflight;

  assign w_ar_hs       = r_arvalid & s_axil_arready;
  assign w_r_hs        = s_axil_rvalid & r_rready;
  assign w_r_dec       = w_r_hs & (r_outstanding != '0);
  assign w_discard     = w_r_hs & (r_drop != '0);
  assign w_push        = w_r_hs & (r_drop == '0) & ~i_Redirect;
  assign w_pop         = (r_count != '0) & i_Instruction_Ready & ~i_Redirect;
  assign w_redirect_pc = {i_Redirect_PC[XLEN-1:2], 2'b00};
  assign w_out_after   = r_outstanding + OW'(w_ar_hs) - OW'(w_r_dec);

  // A pending (not yet accepted) request already holds a credit, so it is counted as in flight.
  assign w_inflight = SW'(r_outstanding) + SW'(r_arvalid);
  assign w_issue    = (~r_arvalid | w_ar_hs) & i_Enable & ~r_stale & ~i_Redirect
                    & (w_inflight < SW'(MAX_OUTSTANDING))
                    & ((w_inflight + SW'(r_count)) < SW'(DEPTH));

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    if (i_Redirect) begin
      w_fetch_pc_next = w_redirect_pc;
    end else if (w_ar_hs && !r_stale) begin
      w_fetch_pc_next = r_fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rready      <= 1'b0;
      r_stale       <= 1'b0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_rready      <= 1'b1;
      r_fetch_pc    <= w_fetch_pc_next;
      r_outstanding <= w_out_after;
      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr  <= w_fetch_pc_next;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      // A request still waiting for arready at redirect time becomes stale and is dropped later.
      if (i_Redirect) begin
        r_drop    <= w_out_after;
        r_stale   <= r_arvalid & ~s_axil_arready;
        r_resp_pc <= w_redirect_pc;
      end else begin
        r_drop <= r_drop + OW'(w_ar_hs & r_stale) - OW'(w_discard);
        if (w_ar_hs) begin
          r_stale <= 1'b0;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (i_Redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_resp_pc;
        r_instr_mem[r_wr_ptr] <= s_axil_rdata;
        r_err_mem[r_wr_ptr]   <= (s_axil_rresp != 2'b00);
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_Instruction       = r_instr_mem[r_rd_ptr];
  assign o_Instruction_PC    = r_pc_mem[r_rd_ptr];
  assign o_Instruction_Error = r_err_mem[r_rd_ptr];
  assign o_Instruction_Valid = (r_count != '0);
  assign o_Count             = r_count;
  assign s_axil_araddr       = r_araddr;
  assign s_axil_arvalid      = r_arvalid;
  assign s_axil_rready       = r_rready;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// tb/tb_instruction_prefetch_queue.sv - directed self-checking bench for instruction_prefetch_queue
module tb_instruction_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  count;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

  logic [31:0] pend_q[$];
  logic [31:0] ar_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        got_err[$];
  logic [31:0] resp_addr;
  logic        r_hold;
  logic [31:0] err_addr;

  instruction_prefetch_queue dut (
    .i_Clock             (clk),
    .i_Reset_N           (rst_n),
    .i_Enable            (enable),
    .i_Redirect          (redirect),
    .i_Redirect_PC       (redirect_pc),
    .o_Instruction       (instr),
    .o_Instruction_PC    (instr_pc),
    .o_Instruction_Error (instr_err),
    .o_Instruction_Valid (instr_valid),
    .i_Instruction_Ready (instr_ready),
    .o_Count             (count),
    .s_axil_araddr       (araddr),
    .s_axil_arvalid      (arvalid),
    .s_axil_arready      (arready),
    .s_axil_rdata        (rdata),
    .s_axil_rresp        (rresp),
    .s_axil_rvalid       (rvalid),
    .s_axil_rready       (rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Memory model: one response per cycle, one cycle after the AR handshake unless held.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
    end else if (arvalid && arready) begin
      pend_q.push_back(araddr);
      ar_log.push_back(araddr);
    end
    #1;
    if (rst_n && !r_hold && pend_q.size() != 0) begin
      resp_addr = pend_q.pop_front();
      rvalid = 1'b1;
      rdata  = mem_word(resp_addr);
      rresp  = (resp_addr == err_addr) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = 2'b00;
    end
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr);
      got_err.push_back(instr_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; arready = 1'b0; r_hold = 1'b0; err_addr = 32'hFFFF_FFFF;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; arready = 1'b0; r_hold = 1'b0; err_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL reset_rready: got %b want 0", rready); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL post_reset_rready: got %b want 1", rready); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL disabled_arvalid: got %b want 0", arvalid); end
  endtask

  task automatic test_stream();
    int base_ar, base_got, n_r, n_v;
    do_reset();
    base_ar = ar_log.size(); base_got = got_pc.size();
    n_r = -1; n_v = -1;
    instr_ready = 1'b1; arready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 60 && got_pc.size() < base_got + 3; i++) begin
      @(negedge clk);
      if (n_r < 0 && rvalid) n_r = i;
      if (n_v < 0 && instr_valid) n_v = i;
    end
    total++; if (got_pc.size() < base_got + 3) begin bad++; $display("FAIL stream_entries: got %0d want 3", got_pc.size() - base_got); end
    total++; if (n_v != n_r + 1) begin bad++; $display("FAIL stream_latency: valid at %0d want %0d", n_v, n_r + 1); end
    if (got_pc.size() >= base_got + 3 && ar_log.size() >= base_ar + 3) begin
      total++; if (ar_log[base_ar + 1] !== 32'h4) begin bad++; $display("FAIL stream_ar1: got %h want 4", ar_log[base_ar + 1]); end
      total++; if (ar_log[base_ar + 2] !== 32'h8) begin bad++; $display("FAIL stream_ar2: got %h want 8", ar_log[base_ar + 2]); end
      total++; if (got_pc[base_got] !== 32'h0) begin bad++; $display("FAIL stream_pc0: got %h want 0", got_pc[base_got]); end
      total++; if (got_pc[base_got + 1] !== 32'h4) begin bad++; $display("FAIL stream_pc1: got %h want 4", got_pc[base_got + 1]); end
      total++; if (got_pc[base_got + 2] !== 32'h8) begin bad++; $display("FAIL stream_pc2: got %h want 8", got_pc[base_got + 2]); end
      total++; if (got_data[base_got + 1] !== 32'hC0DE_0004) begin bad++; $display("FAIL stream_data1: got %h want c0de0004", got_data[base_got + 1]); end
      total++; if (got_err[base_got + 2] !== 1'b0) begin bad++; $display("FAIL stream_err2: got %b want 0", got_err[base_got + 2]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int base_ar;
    do_reset();
    base_ar = ar_log.size();
    instr_ready = 1'b0; arready = 1'b1; enable = 1'b1;
    tick(30);
    @(negedge clk);
    total++; if (ar_log.size() - base_ar != 4) begin bad++; $display("FAIL bp_ar_count: got %0d want 4", ar_log.size() - base_ar); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count_full: got %0d want 4", count); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL bp_arvalid_full: got %b want 0", arvalid); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got %h want 0", instr_pc); end
    tick(1);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    tick(10);
    @(negedge clk);
    total++; if (ar_log.size() - base_ar != 5) begin bad++; $display("FAIL bp_ar_after_pop: got %0d want 5", ar_log.size() - base_ar); end
    if (ar_log.size() >= base_ar + 5) begin
      total++; if (ar_log[base_ar + 4] !== 32'h10) begin bad++; $display("FAIL bp_ar_addr: got %h want 10", ar_log[base_ar + 4]); end
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count_refill: got %0d want 4", count); end
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL bp_head_after_pop: got %h want 4", instr_pc); end
    enable = 1'b0;
  endtask

  task automatic test_redirect_inflight();
    int base_ar, base_got;
    do_reset();
    base_ar = ar_log.size(); base_got = got_pc.size();
    r_hold = 1'b1; arready = 1'b1; instr_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40 && ar_log.size() < base_ar + 2; i++) @(negedge clk);
    tick(2);
    @(negedge clk);
    total++; if (ar_log.size() - base_ar != 2) begin bad++; $display("FAIL rdi_outstanding: got %0d want 2", ar_log.size() - base_ar); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rdi_arvalid_limit: got %b want 0", arvalid); end
    tick(1);
    redirect = 1'b1; redirect_pc = 32'h0000_0101;
    tick(1);
    redirect = 1'b0;
    @(negedge clk);
    r_hold = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rdi_count: got %0d want 0", count); end
    for (int i = 0; i < 40 && got_pc.size() < base_got + 1; i++) @(negedge clk);
    total++; if (got_pc.size() < base_got + 1) begin bad++; $display("FAIL rdi_entry: got %0d want 1", got_pc.size() - base_got); end
    if (got_pc.size() >= base_got + 1 && ar_log.size() >= base_ar + 3) begin
      total++; if (got_pc[base_got] !== 32'h100) begin bad++; $display("FAIL rdi_pc: got %h want 100", got_pc[base_got]); end
      total++; if (got_data[base_got] !== 32'hC0DE_0100) begin bad++; $display("FAIL rdi_data: got %h want c0de0100", got_data[base_got]); end
      total++; if (ar_log[base_ar + 2] !== 32'h100) begin bad++; $display("FAIL rdi_ar: got %h want 100", ar_log[base_ar + 2]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_redirect_stale();
    int base_ar, base_got;
    do_reset();
    base_ar = ar_log.size(); base_got = got_pc.size();
    arready = 1'b1; instr_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40 && ar_log.size() < base_ar + 2; i++) @(negedge clk);
    tick(1);
    arready = 1'b0;
    for (int i = 0; i < 20 && !(got_pc.size() >= base_got + 2 && count == 3'd0 && arvalid); i++) @(negedge clk);
    total++; if (araddr !== 32'h8) begin bad++; $display("FAIL rds_pending_addr: got %h want 8", araddr); end
    tick(1);
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick(1);
    redirect = 1'b0;
    tick(2);
    @(negedge clk);
    total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL rds_hold_valid: got %b want 1", arvalid); end
    total++; if (araddr !== 32'h8) begin bad++; $display("FAIL rds_hold_addr: got %h want 8", araddr); end
    tick(1);
    arready = 1'b1;
    for (int i = 0; i < 40 && got_pc.size() < base_got + 3; i++) @(negedge clk);
    total++; if (got_pc.size() < base_got + 3) begin bad++; $display("FAIL rds_entries: got %0d want 3", got_pc.size() - base_got); end
    if (got_pc.size() >= base_got + 3 && ar_log.size() >= base_ar + 4) begin
      total++; if (got_pc[base_got + 2] !== 32'h40) begin bad++; $display("FAIL rds_pc: got %h want 40", got_pc[base_got + 2]); end
      total++; if (got_data[base_got + 2] !== 32'hC0DE_0040) begin bad++; $display("FAIL rds_data: got %h want c0de0040", got_data[base_got + 2]); end
      total++; if (ar_log[base_ar + 2] !== 32'h8) begin bad++; $display("FAIL rds_ar_stale: got %h want 8", ar_log[base_ar + 2]); end
      total++; if (ar_log[base_ar + 3] !== 32'h40) begin bad++; $display("FAIL rds_ar_next: got %h want 40", ar_log[base_ar + 3]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_error();
    int base_got;
    do_reset();
    base_got = got_pc.size();
    err_addr = 32'h4;
    arready = 1'b1; instr_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 60 && got_pc.size() < base_got + 3; i++) @(negedge clk);
    total++; if (got_pc.size() < base_got + 3) begin bad++; $display("FAIL err_entries: got %0d want 3", got_pc.size() - base_got); end
    if (got_pc.size() >= base_got + 3) begin
      total++; if (got_err[base_got] !== 1'b0) begin bad++; $display("FAIL err_pc0: got %b want 0", got_err[base_got]); end
      total++; if (got_err[base_got + 1] !== 1'b1) begin bad++; $display("FAIL err_pc4: got %b want 1", got_err[base_got + 1]); end
      total++; if (got_pc[base_got + 1] !== 32'h4) begin bad++; $display("FAIL err_pc4_addr: got %h want 4", got_pc[base_got + 1]); end
      total++; if (got_err[base_got + 2] !== 1'b0) begin bad++; $display("FAIL err_pc8: got %b want 0", got_err[base_got + 2]); end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int base_ar, base_got;
    do_reset();
    base_ar = ar_log.size();
    instr_ready = 1'b0; arready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40 && count != 3'd2; i++) @(negedge clk);
    r_hold = 1'b1;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL mf_pre_count: got %0d want 2", count); end
    for (int i = 0; i < 40 && ar_log.size() < base_ar + 4; i++) @(negedge clk);
    total++; if (ar_log.size() - base_ar != 4) begin bad++; $display("FAIL mf_pre_ar: got %0d want 4", ar_log.size() - base_ar); end
    tick(1);
    rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mf_count: got %0d want 0", count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mf_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mf_instr: got %h want 0", instr); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL mf_arvalid: got %b want 0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL mf_rready: got %b want 0", rready); end
    tick(2);
    r_hold = 1'b0;
    base_ar = ar_log.size(); base_got = got_pc.size();
    instr_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 40 && got_pc.size() < base_got + 1; i++) @(negedge clk);
    total++; if (got_pc.size() < base_got + 1) begin bad++; $display("FAIL mf_resume: got %0d want 1", got_pc.size() - base_got); end
    if (got_pc.size() >= base_got + 1 && ar_log.size() >= base_ar + 1) begin
      total++; if (ar_log[base_ar] !== 32'h0) begin bad++; $display("FAIL mf_first_ar: got %h want 0", ar_log[base_ar]); end
      total++; if (got_pc[base_got] !== 32'h0) begin bad++; $display("FAIL mf_first_pc: got %h want 0", got_pc[base_got]); end
      total++; if (got_data[base_got] !== 32'hC0DE_0000) begin bad++; $display("FAIL mf_first_data: got %h want c0de0000", got_data[base_got]); end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_stale();
    test_error();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
